// File: rtl/lcd_frame_sink_pkg.sv
// Shared PPU-side definitions for the LCD frame sink: sink states and the
// default screen geometry with the byte counts derived from it.
package lcd_frame_sink_pkg;

  localparam int LCD_X_MAX          = 160;
  localparam int LCD_Y_MAX          = 144;
  localparam int LCD_BYTES_PER_LINE = LCD_X_MAX / 4;
  localparam int LCD_FRAME_BYTES    = LCD_X_MAX * LCD_Y_MAX / 4;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACTIVE   = 2'd1,
    DRAIN    = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/fb_write_fifo.sv
// Small FIFO of {address, byte} words with a registered head word; capacity
// counts the head register, so DEPTH words can be held in total.
module fb_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             head_valid_reg;
  logic             head_free, mem_has, mem_read, mem_write;

  // The head slot frees up when it is popped or was never filled.
  assign head_free = !head_valid_reg || pop;
  assign mem_has   = count_reg > CW'(head_valid_reg);
  assign mem_read  = head_free && mem_has;
  assign mem_write = push && !(head_free && !mem_has);

  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (head_free) begin
        if (mem_read) begin
          head_data_reg  <= mem[rd_ptr_reg];
          head_valid_reg <= 1'b1;
          rd_ptr_reg     <= rd_ptr_reg + PW'(1);
        end else if (push) begin
          head_data_reg  <= push_data;
          head_valid_reg <= 1'b1;
        end else begin
          head_valid_reg <= 1'b0;
        end
      end
      if (mem_write) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;
  assign full       = count_reg == CW'(DEPTH);
  assign empty      = count_reg == '0;

endmodule

// File: rtl/lcd_frame_sink.sv
// PPU pixel sink: packs 2-bit shades four per byte into framebuffer writes.
// Define LCD_SINK_DOUBLE_BUFFER_EN to alternate between two framebuffer halves.
module lcd_frame_sink
  import lcd_frame_sink_pkg::*;
#(
  parameter int X_MAX         = LCD_X_MAX,
  parameter int Y_MAX         = LCD_Y_MAX,
  parameter int FIFO_DEPTH    = 4,
  parameter int FB_ADDR_WIDTH = 14
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       lcd_en_in,
  input  logic                       vblank_in,
  input  logic [1:0]                 pixel_in,
  input  logic                       pixel_valid_in,
  output logic [FB_ADDR_WIDTH-1:0]   fb_addr_out,
  output logic [7:0]                 fb_data_out,
  output logic                       fb_we_out,
  input  logic                       fb_ready_in,
  output logic                       front_buffer_out,
  output logic                       frame_done_out,
  output logic                       error_out,
  output logic [$clog2(X_MAX)-1:0]   x_out,
  output logic [$clog2(Y_MAX)-1:0]   y_out
);

  localparam int XW          = $clog2(X_MAX);
  localparam int YW          = $clog2(Y_MAX);
  localparam int FRAME_BYTES = X_MAX * Y_MAX / 4;

`ifdef LCD_SINK_DOUBLE_BUFFER_EN
  localparam bit DOUBLE_BUFFER = 1'b1;
`else
  localparam bit DOUBLE_BUFFER = 1'b0;
`endif

  localparam logic [FB_ADDR_WIDTH-1:0] BACK_OFFSET =
    DOUBLE_BUFFER ? FB_ADDR_WIDTH'(FRAME_BYTES) : '0;

  // Frames are written into the half not currently shown.
  function automatic logic [FB_ADDR_WIDTH-1:0] back_base(input logic front);
    return front ? '0 : BACK_OFFSET;
  endfunction

  lcd_state_e                state_reg;
  logic [XW-1:0]             x_reg;
  logic [YW-1:0]             y_reg;
  logic [5:0]                packer_reg;
  logic [FB_ADDR_WIDTH-1:0]  byte_addr_reg;
  logic                      vblank_prev_reg, complete_reg, front_reg;
  logic                      frame_done_reg, error_reg;

  logic [FB_ADDR_WIDTH+7:0]  head_word;
  logic                      head_valid, fifo_full, fifo_empty;
  logic                      fifo_push, fifo_pop, byte_done, short_frame;

  assign short_frame = (state_reg == ACTIVE) && vblank_in && !vblank_prev_reg &&
                       ((x_reg != '0) || (y_reg != '0));
  assign byte_done   = (state_reg == ACTIVE) && lcd_en_in && pixel_valid_in &&
                       !short_frame && (x_reg[1:0] == 2'd3);
  assign fifo_pop    = head_valid && fb_ready_in;
  assign fifo_push   = byte_done && (!fifo_full || fifo_pop);

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FB_ADDR_WIDTH + 8)
  ) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .flush      (!lcd_en_in),
    .push       (fifo_push),
    .push_data  ({byte_addr_reg, pixel_in, packer_reg}),
    .pop        (fifo_pop),
    .head_data  (head_word),
    .head_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg       <= DISABLED;
      x_reg           <= '0;
      y_reg           <= '0;
      packer_reg      <= '0;
      byte_addr_reg   <= '0;
      vblank_prev_reg <= 1'b0;
      complete_reg    <= 1'b0;
      front_reg       <= 1'b0;
      frame_done_reg  <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      vblank_prev_reg <= vblank_in;
      frame_done_reg  <= 1'b0;
      if (!lcd_en_in) begin
        state_reg     <= DISABLED;
        x_reg         <= '0;
        y_reg         <= '0;
        packer_reg    <= '0;
        byte_addr_reg <= '0;
        complete_reg  <= 1'b0;
        error_reg     <= 1'b0;
      end else begin
        case (state_reg)
          DISABLED: begin
            state_reg     <= ACTIVE;
            x_reg         <= '0;
            y_reg         <= '0;
            packer_reg    <= '0;
            byte_addr_reg <= back_base(front_reg);
          end
          ACTIVE: begin
            if (short_frame) begin
              packer_reg   <= '0;
              error_reg    <= 1'b1;
              complete_reg <= 1'b0;
              state_reg    <= DRAIN;
            end else if (pixel_valid_in) begin
              packer_reg <= {pixel_in, packer_reg[5:2]};
              if (byte_done) begin
                byte_addr_reg <= byte_addr_reg + FB_ADDR_WIDTH'(1);
                if (!fifo_push) error_reg <= 1'b1;
              end
              if (x_reg == XW'(X_MAX - 1)) begin
                x_reg <= '0;
                if (y_reg == YW'(Y_MAX - 1)) begin
                  y_reg        <= '0;
                  complete_reg <= 1'b1;
                  state_reg    <= DRAIN;
                end else begin
                  y_reg <= y_reg + YW'(1);
                end
              end else begin
                x_reg <= x_reg + XW'(1);
              end
            end
          end
          DRAIN: begin
            if (pixel_valid_in) error_reg <= 1'b1;
            // Wait for every queued byte of this frame to be accepted.
            if (fifo_empty) begin
              state_reg    <= ACTIVE;
              x_reg        <= '0;
              y_reg        <= '0;
              packer_reg   <= '0;
              complete_reg <= 1'b0;
              if (complete_reg) begin
                frame_done_reg <= 1'b1;
                front_reg      <= front_reg ^ DOUBLE_BUFFER;
                byte_addr_reg  <= back_base(front_reg ^ DOUBLE_BUFFER);
              end else begin
                byte_addr_reg  <= back_base(front_reg);
              end
            end
          end
          default: state_reg <= DISABLED;
        endcase
      end
    end
  end

  assign fb_addr_out      = head_word[FB_ADDR_WIDTH+7:8];
  assign fb_data_out      = head_word[7:0];
  assign fb_we_out        = head_valid;
  assign front_buffer_out = front_reg;
  assign frame_done_out   = frame_done_reg;
  assign error_out        = error_reg;
  assign x_out            = x_reg;
  assign y_out            = y_reg;

endmodule

// File: tb/tb_lcd_frame_sink.sv
// Directed bench for lcd_frame_sink: full frame, back-pressure, overflow,
// disable mid-line and short frame, with hand-computed expectations.
module tb_lcd_frame_sink;

  localparam int AW = 14;
`ifdef LCD_SINK_DOUBLE_BUFFER_EN
  localparam int BASE1  = 5760;
  localparam int FRONT1 = 1;
`else
  localparam int BASE1  = 0;
  localparam int FRONT1 = 0;
`endif
  // After the first frame completes, the back buffer is offset 0 in both builds.
  localparam int BASE2 = 0;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          lcd_en_in = 1'b0;
  logic          vblank_in = 1'b0;
  logic [1:0]    pixel_in = 2'd0;
  logic          pixel_valid_in = 1'b0;
  logic [AW-1:0] fb_addr_out;
  logic [7:0]    fb_data_out;
  logic          fb_we_out;
  logic          fb_ready_in = 1'b0;
  logic          front_buffer_out;
  logic          frame_done_out;
  logic          error_out;
  logic [7:0]    x_out;
  logic [7:0]    y_out;

  lcd_frame_sink #(
    .X_MAX(160), .Y_MAX(144), .FIFO_DEPTH(4), .FB_ADDR_WIDTH(AW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .lcd_en_in        (lcd_en_in),
    .vblank_in        (vblank_in),
    .pixel_in         (pixel_in),
    .pixel_valid_in   (pixel_valid_in),
    .fb_addr_out      (fb_addr_out),
    .fb_data_out      (fb_data_out),
    .fb_we_out        (fb_we_out),
    .fb_ready_in      (fb_ready_in),
    .front_buffer_out (front_buffer_out),
    .frame_done_out   (frame_done_out),
    .error_out        (error_out),
    .x_out            (x_out),
    .y_out            (y_out)
  );

  always #5 clk_in = ~clk_in;

  int assert_count = 0;
  int fail_count   = 0;
  int done_count   = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (fb_we_out && fb_ready_in) begin
        wr_addr_q.push_back(fb_addr_out);
        wr_data_q.push_back(fb_data_out);
      end
      if (frame_done_out) done_count++;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  function automatic logic [31:0] q_addr(input int k);
    if (k < wr_addr_q.size()) return 32'(wr_addr_q[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] q_data(input int k);
    if (k < wr_data_q.size()) return 32'(wr_data_q[k]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    logic [1:0] stall_pix [8];
    logic [1:0] tail_pix [4];
    stall_pix = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    tail_pix  = '{2'd0, 2'd3, 2'd0, 2'd3};

    // Reset state
    #2;
    check_value("rst fb_we", 32'(fb_we_out), 0);
    check_value("rst fb_addr", 32'(fb_addr_out), 0);
    check_value("rst fb_data", 32'(fb_data_out), 0);
    check_value("rst front", 32'(front_buffer_out), 0);
    check_value("rst frame_done", 32'(frame_done_out), 0);
    check_value("rst error", 32'(error_out), 0);
    check_value("rst x", 32'(x_out), 0);
    check_value("rst y", 32'(y_out), 0);
    $display("reset values checked");

    tick(); tick();
    rst_in = 1'b0;
    lcd_en_in = 1'b1;
    fb_ready_in = 1'b1;
    tick();

    // Full frame with shades 0,1,2,3 repeating
    clear_writes();
    for (int i = 0; i < 23040; i++) begin
      pixel_in = 2'(i % 4);
      pixel_valid_in = 1'b1;
      tick();
      if (i == 159) begin
        check_value("line wrap x", 32'(x_out), 0);
        check_value("line wrap y", 32'(y_out), 1);
      end
    end
    pixel_valid_in = 1'b0;
    check_value("frame_done before last write", 32'(frame_done_out), 0);
    tick();
    check_value("frame_done at last write", 32'(frame_done_out), 0);
    check_value("front before done", 32'(front_buffer_out), 0);
    tick();
    check_value("frame_done pulse", 32'(frame_done_out), 1);
    check_value("front after done", 32'(front_buffer_out), 32'(FRONT1));
    tick();
    check_value("frame_done one cycle", 32'(frame_done_out), 0);
    check_value("frame write count", 32'(wr_addr_q.size()), 5760);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != AW'(BASE1 + i) || wr_data_q[i] != 8'hE4) bad++;
    end
    check_value("frame bad entries", 32'(bad), 0);
    check_value("frame first addr", q_addr(0), 32'(BASE1));
    check_value("frame last addr", q_addr(5759), 32'(BASE1 + 5759));
    check_value("frame error", 32'(error_out), 0);
    check_value("frame done count", 32'(done_count), 1);
    $display("full frame: %0d writes, %0d done pulses", wr_addr_q.size(), done_count);

    // Back-pressure for 3 cycles while 8 pixels arrive
    clear_writes();
    for (int k = 0; k < 8; k++) begin
      pixel_in = stall_pix[k];
      pixel_valid_in = 1'b1;
      fb_ready_in = !(k >= 4 && k <= 6);
      if (k >= 4 && k <= 6) begin
        check_value("stall we", 32'(fb_we_out), 1);
        check_value("stall addr", 32'(fb_addr_out), 32'(BASE2));
        check_value("stall data", 32'(fb_data_out), 32'h1B);
      end
      tick();
    end
    pixel_valid_in = 1'b0;
    fb_ready_in = 1'b1;
    repeat (3) tick();
    check_value("stall write count", 32'(wr_addr_q.size()), 2);
    check_value("stall addr0", q_addr(0), 32'(BASE2));
    check_value("stall data0", q_data(0), 32'h1B);
    check_value("stall addr1", q_addr(1), 32'(BASE2 + 1));
    check_value("stall data1", q_data(1), 32'hA5);
    check_value("stall error", 32'(error_out), 0);
    check_value("stall x", 32'(x_out), 8);
    $display("back-pressure: %0d writes", wr_addr_q.size());

    // Overflow: 6 bytes with the write port blocked, depth 4
    clear_writes();
    fb_ready_in = 1'b0;
    for (int j = 0; j < 24; j++) begin
      pixel_in = 2'((j / 4) % 4);
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    check_value("overflow error", 32'(error_out), 1);
    check_value("overflow no early writes", 32'(wr_addr_q.size()), 0);
    fb_ready_in = 1'b1;
    repeat (6) tick();
    check_value("overflow write count", 32'(wr_addr_q.size()), 4);
    check_value("overflow addr0", q_addr(0), 32'(BASE2 + 2));
    check_value("overflow data0", q_data(0), 32'h00);
    check_value("overflow data1", q_data(1), 32'h55);
    check_value("overflow data2", q_data(2), 32'hAA);
    check_value("overflow addr3", q_addr(3), 32'(BASE2 + 5));
    check_value("overflow data3", q_data(3), 32'hFF);
    check_value("overflow x", 32'(x_out), 32);
    $display("overflow: %0d writes kept", wr_addr_q.size());

    // Disable mid-line with 2 bytes queued
    clear_writes();
    fb_ready_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      pixel_in = 2'd1;
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    check_value("disable queued we", 32'(fb_we_out), 1);
    lcd_en_in = 1'b0;
    tick();
    check_value("disable we", 32'(fb_we_out), 0);
    check_value("disable x", 32'(x_out), 0);
    check_value("disable y", 32'(y_out), 0);
    check_value("disable error", 32'(error_out), 0);
    fb_ready_in = 1'b1;
    tick(); tick();
    check_value("disable discarded", 32'(wr_addr_q.size()), 0);
    lcd_en_in = 1'b1;
    tick();
    check_value("disable front kept", 32'(front_buffer_out), 32'(FRONT1));
    $display("disable: pending bytes discarded");

    // Short frame: vblank rises at (37,100)
    clear_writes();
    for (int i = 0; i < 16037; i++) begin
      pixel_in = 2'(i % 4);
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    check_value("short x", 32'(x_out), 37);
    check_value("short y", 32'(y_out), 100);
    check_value("short error before", 32'(error_out), 0);
    vblank_in = 1'b1;
    repeat (10) tick();
    check_value("short error", 32'(error_out), 1);
    check_value("short no done", 32'(done_count), 1);
    check_value("short front", 32'(front_buffer_out), 32'(FRONT1));
    check_value("short write count", 32'(wr_addr_q.size()), 4009);
    check_value("short last addr", q_addr(4008), 32'(BASE2 + 4008));
    clear_writes();
    vblank_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pixel_in = tail_pix[k];
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    repeat (3) tick();
    check_value("restart write count", 32'(wr_addr_q.size()), 1);
    check_value("restart addr", q_addr(0), 32'(BASE2));
    check_value("restart data", q_data(0), 32'hCC);
    $display("short frame: restart at same buffer base");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
